// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C target with START/STOP detection and a byte-wide rx/tx interface to user logic.
// Latency: pads pass SYNC_STAGES flops plus one edge flop; sda_oe and the pulses register 1 clock after an edge is detected.
// Backpressure: none (no clock stretching); rx_valid must be taken when pulsed and tx_data must already be valid at the ACK falling edge that fires tx_req.
// Optional macro GENERAL_CALL_EN: also ACK address 7'h00 with rw=0 (general call write); undefined means only TARGET_ADDR is ACKed.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       addressed,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       tx_nack
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

  // Synchronisers reset to 1 so an idle (pulled-up) bus produces no edge when reset lifts.
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  // Bring the asynchronous pad inputs into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Previous synchronised values, used for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SDA may only move while SCL is low during data, so an SDA edge with SCL held high is a bus condition.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       phase;
  logic [7:0] rx_byte;
  logic       addr_hit;

  // The byte as it stands once the bit currently on the bus is shifted in.
  assign rx_byte = {shreg[6:0], sda_s};

`ifdef GENERAL_CALL_EN
  assign addr_hit = (rx_byte[7:1] == TARGET_ADDR) ||
                    ((rx_byte[7:1] == 7'h00) && !rx_byte[0]);
`else
  assign addr_hit = (rx_byte[7:1] == TARGET_ADDR);
`endif

  // Protocol FSM. In ADDR_ACK/RX_ACK sda_oe doubles as the phase flag: the first SCL fall
  // starts driving the ACK, the second (end of the 9th clock) ends it. In TX/TX_ACK the
  // separate phase bit marks "last data bit sampled" and "controller ACKed" respectively.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      phase     <= 1'b0;
      sda_oe    <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      tx_nack   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      tx_nack  <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        phase     <= 1'b0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        phase     <= 1'b0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
          end

          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_hit) begin
                  state <= ADDR_ACK;
                  rw    <= sda_s;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe    <= 1'b1;
                addressed <= 1'b1;
              end else if (rw) begin
                state  <= TX;
                tx_req <= 1'b1;
                shreg  <= {tx_data[6:0], 1'b0};
                sda_oe <= ~tx_data[7];
              end else begin
                state  <= RX;
                sda_oe <= 1'b0;
              end
            end
          end

          RX: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
                state    <= RX_ACK;
              end
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX;
              end
            end
          end

          TX: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                phase <= 1'b1;
              end
            end else if (scl_fall) begin
              if (phase) begin
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                phase <= 1'b1;
              end else begin
                tx_nack <= 1'b1;
                state   <= WAIT_STOP;
              end
            end else if (scl_fall && phase) begin
              phase  <= 1'b0;
              state  <= TX;
              tx_req <= 1'b1;
              shreg  <= {tx_data[6:0], 1'b0};
              sda_oe <= ~tx_data[7];
            end
          end

          WAIT_STOP: begin
            bit_cnt <= 3'd0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C controller drives the bus; a transaction-level
// model (which addresses ACK, which bytes reach user logic, what SDA must show) predicts outputs.
module tb_i2c_target;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       scl_ctrl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       sda_oe;
  logic       addressed;
  logic       rw;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       tx_nack;
  logic       sda_bus;

  // Open-drain wired-AND of controller and target.
  assign sda_bus = sda_ctrl & ~sda_oe;

  i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .scl_in    (scl_ctrl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .addressed (addressed),
    .rw        (rw),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .tx_nack   (tx_nack)
  );

  always #5 clock = ~clock;

  localparam int Q = 50;  // quarter SCL period: 5 clocks, SCL = 20x slower than clock
`ifdef GENERAL_CALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  int cnt_rxv = 0;
  int cnt_req = 0;
  int cnt_nack = 0;
  logic win = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_addr = 1'b0;
  logic [7:0] exp_rx[$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", nm, act, want);
  endtask

  // Model: which addresses the target answers.
  function automatic logic acks(input logic [6:0] a, input logic r);
    return (a == 7'h42) || (GC && (a == 7'h00) && !r);
  endfunction

  // Compare process: pulses vs model queue every cycle, bus drive/addressed mid-SCL-high.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (rx_valid || tx_req || tx_nack) begin
          check("single_pulse", 8'(rx_valid) + 8'(tx_req) + 8'(tx_nack), 8'd1);
          if (rx_valid) begin
            cnt_rxv++;
            check("rx_expected", 8'(exp_rx.size() > 0), 8'd1);
            if (exp_rx.size() > 0) check("rx_data", rx_data, exp_rx.pop_front());
          end
          if (tx_req) cnt_req++;
          if (tx_nack) cnt_nack++;
        end
        if (win) begin
          check("sda_oe_bit", 8'(sda_oe), 8'(exp_oe));
          check("addressed_bit", 8'(addressed), 8'(exp_addr));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_bit(input logic b, input logic eo, input logic ea, output logic s);
    #Q sda_ctrl = b; exp_oe = eo; exp_addr = ea;
    #Q scl_ctrl = 1'b1;
    #Q win = 1'b1; s = sda_bus;
    #Q win = 1'b0; scl_ctrl = 1'b0;
  endtask

  task automatic start_c;
    #Q sda_ctrl = 1'b1;
    #Q scl_ctrl = 1'b1;
    #Q sda_ctrl = 1'b0;
    #Q scl_ctrl = 1'b0;
  endtask

  task automatic stop_c;
    #Q sda_ctrl = 1'b0;
    #Q scl_ctrl = 1'b1;
    #Q sda_ctrl = 1'b1;
    #Q;
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic r, output logic m);
    logic s;
    logic [7:0] b;
    b = {a, r};
    for (int i = 7; i >= 0; i--) do_bit(b[i], 1'b0, 1'b0, s);
    m = acks(a, r);
    do_bit(1'b1, m, m, s);
    check("addr_ack", 8'(s), 8'(!m));
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic m);
    logic s;
    if (m) exp_rx.push_back(d);
    for (int i = 7; i >= 0; i--) do_bit(d[i], 1'b0, m, s);
    do_bit(1'b1, m, m, s);
    check("data_ack", 8'(s), 8'(!m));
  endtask

  task automatic rd_byte(input logic [7:0] want, input logic [7:0] next_tx, input logic nack);
    logic s;
    logic [7:0] got;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, ~want[i], 1'b1, s);
      got[i] = s;
    end
    tx_data = next_tx;
    do_bit(nack, 1'b0, 1'b1, s);
    check("rd_byte", got, want);
  endtask

  initial begin
    logic m;
    logic s;
    int b_rx;
    int b_req;
    int b_nack;

    #3;
    #20;
    check("rst_sda_oe", 8'(sda_oe), 8'd0);
    check("rst_addressed", 8'(addressed), 8'd0);
    check("rst_rw", 8'(rw), 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {5'd0, rx_valid, tx_req, tx_nack}, 8'd0);
    #10 reset = 1'b0;
    #100;

    // Write 0xA5 to 0x42.
    b_rx = cnt_rxv;
    start_c;
    addr_phase(7'h42, 1'b0, m);
    check("t1_addressed_ack", 8'(addressed), 8'd1);
    wr_byte(8'hA5, m);
    stop_c;
    #Q;
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_rx_count", 8'(cnt_rxv - b_rx), 8'd1);
    check("t1_addressed_stop", 8'(addressed), 8'd0);
    check("t1_rw", 8'(rw), 8'd0);

    // Read 0x3C, controller NACKs.
    b_req = cnt_req; b_nack = cnt_nack;
    tx_data = 8'h3C;
    start_c;
    addr_phase(7'h42, 1'b1, m);
    rd_byte(8'h3C, 8'h3C, 1'b1);
    check("t2_rw", 8'(rw), 8'd1);
    stop_c;
    #Q;
    check("t2_tx_req", 8'(cnt_req - b_req), 8'd1);
    check("t2_tx_nack", 8'(cnt_nack - b_nack), 8'd1);

    // Foreign address 0x50: no drive, no data.
    b_rx = cnt_rxv;
    start_c;
    addr_phase(7'h50, 1'b0, m);
    wr_byte(8'h12, m);
    stop_c;
    #Q;
    check("t3_rx_count", 8'(cnt_rxv - b_rx), 8'd0);
    check("t3_rx_data_kept", rx_data, 8'hA5);

    // Write 0x11, repeated START, read 0x5A.
    start_c;
    addr_phase(7'h42, 1'b0, m);
    wr_byte(8'h11, m);
    check("t4_rx_data", rx_data, 8'h11);
    check("t4_rw_w", 8'(rw), 8'd0);
    tx_data = 8'h5A;
    b_req = cnt_req;
    start_c;
    #Q;
    check("t4_addressed_rs", 8'(addressed), 8'd0);
    addr_phase(7'h42, 1'b1, m);
    check("t4_no_req_before_ack_end", 8'(cnt_req - b_req), 8'd0);
    rd_byte(8'h5A, 8'h5A, 1'b1);
    check("t4_rw_r", 8'(rw), 8'd1);
    check("t4_tx_req", 8'(cnt_req - b_req), 8'd1);
    stop_c;

    // Two-byte read: ACK then NACK.
    b_req = cnt_req; b_nack = cnt_nack;
    tx_data = 8'hC3;
    start_c;
    addr_phase(7'h42, 1'b1, m);
    rd_byte(8'hC3, 8'h96, 1'b0);
    rd_byte(8'h96, 8'h00, 1'b1);
    stop_c;
    #Q;
    check("t8_tx_req", 8'(cnt_req - b_req), 8'd2);
    check("t8_tx_nack", 8'(cnt_nack - b_nack), 8'd1);

    // Reset in the middle of a read of 0x00 (target pulling SDA low).
    tx_data = 8'h00;
    start_c;
    addr_phase(7'h42, 1'b1, m);
    for (int i = 0; i < 3; i++) do_bit(1'b1, 1'b1, 1'b1, s);
    #Q sda_ctrl = 1'b1;
    #Q scl_ctrl = 1'b1;
    #Q;
    check("t5_oe_before_reset", 8'(sda_oe), 8'd1);
    reset = 1'b1;
    #1;
    check("t5_oe_async_release", 8'(sda_oe), 8'd0);
    check("t5_addressed_reset", 8'(addressed), 8'd0);
    #(Q - 1) scl_ctrl = 1'b0;
    #Q;
    #Q reset = 1'b0;
    #Q;
    check("t5_rw_reset", 8'(rw), 8'd0);

    // Bus recovers: write 0x77.
    start_c;
    addr_phase(7'h42, 1'b0, m);
    wr_byte(8'h77, m);
    stop_c;
    #Q;
    check("t6_rx_data", rx_data, 8'h77);

    // General call address 0x00, write.
    b_rx = cnt_rxv;
    start_c;
    addr_phase(7'h00, 1'b0, m);
    check("t7_addressed", 8'(addressed), 8'(GC));
    wr_byte(8'h33, m);
    stop_c;
    #Q;
    check("t7_rx_count", 8'(cnt_rxv - b_rx), 8'(GC));

    check("rx_queue_drained", 8'(exp_rx.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
